// File: rtl/comm_pkg.sv
// Shared message-type definitions and payload widths for the comm link (sender, receiver, scheduler).
package comm_pkg;

    localparam int unsigned BALL_Y_W = 9;
    localparam int unsigned VEL_W    = 4;
    localparam int unsigned SCORE_W  = 5;

    typedef enum logic [2:0] {
        MSG_NONE,
        MSG_BALL,
        MSG_MISS,
        MSG_NEW_GAME,
        MSG_NEW_GAME_ACK
    } msg_type_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } tx_state_t;

    // Launch priority, highest first: ack, new_game, miss, ball.
    function automatic msg_type_t msg_pick(input logic ack, input logic ng,
                                           input logic miss, input logic ball);
        if (ack)  return MSG_NEW_GAME_ACK;
        if (ng)   return MSG_NEW_GAME;
        if (miss) return MSG_MISS;
        if (ball) return MSG_BALL;
        return MSG_NONE;
    endfunction

endpackage

// File: rtl/comm_retry_timer.sv
// Ack timeout counter and retry bookkeeping for one new_game episode.
module comm_retry_timer
    import comm_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRIES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_episode_start,
    input  logic i_send_done,
    input  logic i_ack_rx,
    output logic o_retry,
    output logic o_ack_accept,
    output logic o_link_up,
    output logic o_link_fail
);

    localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic          r_active;
    logic          r_running;
    logic [CW-1:0] r_count;
    logic [RW-1:0] r_retries;
    logic          w_timeout;

    // A new episode overrides everything else in the same cycle, and an ack beats a coincident timeout.
    assign o_ack_accept = r_active && i_ack_rx && !i_episode_start;
    assign w_timeout    = r_running && (r_count == CW'(ACK_TIMEOUT - 1)) && !i_ack_rx && !i_episode_start;
    assign o_retry      = w_timeout && (r_retries < RW'(MAX_RETRIES));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active    <= 1'b0;
            r_running   <= 1'b0;
            r_count     <= '0;
            r_retries   <= '0;
            o_link_up   <= 1'b0;
            o_link_fail <= 1'b0;
        end else if (i_episode_start) begin
            r_active    <= 1'b1;
            r_running   <= 1'b0;
            r_count     <= '0;
            r_retries   <= '0;
            o_link_up   <= 1'b0;
            o_link_fail <= 1'b0;
        end else if (o_ack_accept) begin
            r_active  <= 1'b0;
            r_running <= 1'b0;
            o_link_up <= 1'b1;
        end else if (w_timeout) begin
            r_running <= 1'b0;
            if (o_retry) begin
                r_retries <= r_retries + RW'(1);
            end else begin
                r_active    <= 1'b0;
                o_link_fail <= 1'b1;
            end
        end else if (i_send_done && r_active) begin
            r_running <= 1'b1;
            r_count   <= '0;
        end else if (r_running) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/comm_tx_scheduler.sv
// Fixed-priority scheduler of game messages onto the CommunicationSender handshake, with new_game retransmit.
module comm_tx_scheduler
    import comm_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRIES = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ball_req,
    input  logic [BALL_Y_W-1:0] ball_y_in,
    input  logic [VEL_W-1:0]    velocity_x_in,
    input  logic [VEL_W-1:0]    velocity_y_in,
    input  logic                sign_y_in,
    input  logic                miss_req,
    input  logic [SCORE_W-1:0]  my_score_in,
    input  logic [SCORE_W-1:0]  your_score_in,
    input  logic                you_should_serve_in,
    input  logic                new_game_req,
    input  logic                you_serve_first_in,
    input  logic                new_game_ack_req,
    input  logic                new_game_ack_rx,
    output logic                send_new_message,
    input  logic                message_sent,
    output logic                ball_message_tx,
    output logic                miss_message_tx,
    output logic                new_game_message_tx,
    output logic                new_game_ack_message_tx,
    output logic [BALL_Y_W-1:0] ball_y_tx,
    output logic [VEL_W-1:0]    velocity_x_tx,
    output logic [VEL_W-1:0]    velocity_y_tx,
    output logic                sign_y_tx,
    output logic [SCORE_W-1:0]  my_score_tx,
    output logic [SCORE_W-1:0]  your_score_tx,
    output logic                you_should_serve_tx,
    output logic                you_serve_first_tx,
    output logic                link_up,
    output logic                link_fail,
    output logic                busy
);

    tx_state_t           r_state;
    logic                r_pend_ball, r_pend_miss, r_pend_ng, r_pend_ack;
    logic [BALL_Y_W-1:0] r_ball_y;
    logic [VEL_W-1:0]    r_vel_x, r_vel_y;
    logic                r_sign_y;
    logic [SCORE_W-1:0]  r_my_score, r_your_score;
    logic                r_should_serve, r_serve_first;

    msg_type_t w_sel;
    logic      w_idle, w_send_done, w_retry, w_ack_accept;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_sel       = w_idle ? msg_pick(r_pend_ack, r_pend_ng, r_pend_miss, r_pend_ball) : MSG_NONE;
    assign w_send_done = (r_state == ST_SEND) && message_sent && new_game_message_tx;
    assign busy        = r_pend_ball || r_pend_miss || r_pend_ng || r_pend_ack || !w_idle;

    comm_retry_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRIES (MAX_RETRIES)
    ) u_retry (
        .i_clk           (clock),
        .i_rst           (reset),
        .i_episode_start (new_game_req),
        .i_send_done     (w_send_done),
        .i_ack_rx        (new_game_ack_rx),
        .o_retry         (w_retry),
        .o_ack_accept    (w_ack_accept),
        .o_link_up       (link_up),
        .o_link_fail     (link_fail)
    );

    // Pending slots: a fresh request outranks the clear from a same-cycle launch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_ball    <= 1'b0;
            r_pend_miss    <= 1'b0;
            r_pend_ng      <= 1'b0;
            r_pend_ack     <= 1'b0;
            r_ball_y       <= '0;
            r_vel_x        <= '0;
            r_vel_y        <= '0;
            r_sign_y       <= 1'b0;
            r_my_score     <= '0;
            r_your_score   <= '0;
            r_should_serve <= 1'b0;
            r_serve_first  <= 1'b0;
        end else begin
            r_pend_ball <= ball_req || (r_pend_ball && (w_sel != MSG_BALL));
            r_pend_miss <= miss_req || (r_pend_miss && (w_sel != MSG_MISS));
            r_pend_ack  <= new_game_ack_req || (r_pend_ack && (w_sel != MSG_NEW_GAME_ACK));
            r_pend_ng   <= new_game_req || w_retry ||
                           (r_pend_ng && (w_sel != MSG_NEW_GAME) && !w_ack_accept);
            if (ball_req) begin
                r_ball_y <= ball_y_in;
                r_vel_x  <= velocity_x_in;
                r_vel_y  <= velocity_y_in;
                r_sign_y <= sign_y_in;
            end
            if (miss_req) begin
                r_my_score     <= my_score_in;
                r_your_score   <= your_score_in;
                r_should_serve <= you_should_serve_in;
            end
            if (new_game_req) r_serve_first <= you_serve_first_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state                 <= ST_IDLE;
            send_new_message        <= 1'b0;
            ball_message_tx         <= 1'b0;
            miss_message_tx         <= 1'b0;
            new_game_message_tx     <= 1'b0;
            new_game_ack_message_tx <= 1'b0;
            ball_y_tx               <= '0;
            velocity_x_tx           <= '0;
            velocity_y_tx           <= '0;
            sign_y_tx               <= 1'b0;
            my_score_tx             <= '0;
            your_score_tx           <= '0;
            you_should_serve_tx     <= 1'b0;
            you_serve_first_tx      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel != MSG_NONE) begin
                        r_state                 <= ST_SEND;
                        send_new_message        <= 1'b1;
                        ball_message_tx         <= (w_sel == MSG_BALL);
                        miss_message_tx         <= (w_sel == MSG_MISS);
                        new_game_message_tx     <= (w_sel == MSG_NEW_GAME);
                        new_game_ack_message_tx <= (w_sel == MSG_NEW_GAME_ACK);
                        if (w_sel == MSG_BALL) begin
                            ball_y_tx     <= r_ball_y;
                            velocity_x_tx <= r_vel_x;
                            velocity_y_tx <= r_vel_y;
                            sign_y_tx     <= r_sign_y;
                        end
                        if (w_sel == MSG_MISS) begin
                            my_score_tx         <= r_my_score;
                            your_score_tx       <= r_your_score;
                            you_should_serve_tx <= r_should_serve;
                        end
                        if (w_sel == MSG_NEW_GAME) you_serve_first_tx <= r_serve_first;
                    end
                end
                ST_SEND: begin
                    if (message_sent) begin
                        r_state                 <= ST_IDLE;
                        send_new_message        <= 1'b0;
                        ball_message_tx         <= 1'b0;
                        miss_message_tx         <= 1'b0;
                        new_game_message_tx     <= 1'b0;
                        new_game_ack_message_tx <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
